// File: rtl/card_pkg.sv
// Shared constants for the card shoe: rank encodings, per-deck counts and FSM state codes,
// plus the Galois tap-mask helper used by card_lfsr.
package card_pkg;

  localparam logic [3:0] RANK_ACE       = 4'd1;
  localparam logic [3:0] RANK_TEN       = 4'd10;
  localparam int         NUM_RANKS      = 10;
  localparam int         CARDS_PER_RANK = 4;
  localparam int         TENS_PER_DECK  = 16;
  localparam int         CARDS_PER_DECK = 52;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FILL   = 3'd1;
  localparam state_t S_SAMPLE = 3'd2;
  localparam state_t S_WALK   = 3'd3;
  localparam state_t S_OUT    = 3'd4;

  // Galois tap masks; widths without a table entry still keep the MSB tap so zero is never reached.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       lfsr_taps = 64'h0000_0000_0000_00B8;
      16:      lfsr_taps = 64'h0000_0000_0000_B400;
      24:      lfsr_taps = 64'h0000_0000_00E1_0000;
      32:      lfsr_taps = 64'h0000_0000_8020_0003;
      default: lfsr_taps = (64'd1 << (w - 1)) | 64'd1;
    endcase
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running Galois LFSR with a synchronous load; a zero load value falls back to SEED.
module card_lfsr
  import card_pkg::*;
#(
  parameter int           W    = 16,
  parameter logic [W-1:0] SEED = {{(W-1){1'b0}}, 1'b1}
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] state
);

  localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

  logic [W-1:0] lfsr_r;
  logic [W-1:0] next_s;

  // One Galois step: shift right, fold the taps in when the bit shifted out is set.
  always_comb begin
    next_s = {1'b0, lfsr_r[W-1:1]};
    if (lfsr_r[0]) begin
      next_s = next_s ^ TAPS;
    end else begin
      next_s = next_s;
    end
  end

  // LFSR register: advances every cycle unless loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_r <= SEED;
    end else if (load) begin
      lfsr_r <= (load_value == '0) ? SEED : load_value;
    end else begin
      lfsr_r <= next_s;
    end
  end

  assign state = lfsr_r;

endmodule

// File: rtl/card_shoe.sv
// Finite multi-deck shoe dealing without replacement over a request/valid handshake.
// Optional CARD_SHOE_SEED_EN adds seed_load/seed ports for reproducible deals.
module card_shoe
  import card_pkg::*;
#(
  parameter int                NUM_DECKS = 1,
  parameter int                CUT_CARDS = 26,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
  localparam int               TOTAL     = CARDS_PER_DECK * NUM_DECKS,
  localparam int               CL_W      = $clog2(TOTAL + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            draw_req,
  input  logic            shuffle_req,
`ifdef CARD_SHOE_SEED_EN
  input  logic            seed_load,
  input  logic [LFSR_W-1:0] seed,
`endif
  output logic            ready,
  output logic            card_valid,
  output logic [3:0]      card_value,
  output logic [CL_W-1:0] cards_left,
  output logic            low_shoe,
  output logic            reshuffled
);

  localparam int IDX_W = $clog2(TOTAL);
  localparam int CW    = IDX_W + 1;
  localparam int CNT_W = $clog2(TENS_PER_DECK * NUM_DECKS + 1);

  localparam logic [CNT_W-1:0] FULL_LOW  = CNT_W'(CARDS_PER_RANK * NUM_DECKS);
  localparam logic [CNT_W-1:0] FULL_TEN  = CNT_W'(TENS_PER_DECK * NUM_DECKS);
  localparam logic [CL_W-1:0]  FULL_LEFT = CL_W'(TOTAL);
  localparam logic [CL_W-1:0]  CUT_V     = CL_W'(CUT_CARDS);

  state_t           state_r;
  logic             pend_r;
  logic [CW-1:0]    cand_r;
  logic [CW-1:0]    acc_r;
  logic [3:0]       rank_r;
  logic [CNT_W-1:0] cnt_r [NUM_RANKS];

  logic [LFSR_W-1:0] lfsr_s;
  logic              seed_take_s;
  logic [LFSR_W-1:0] seed_val_s;
  logic [CW-1:0]     cand_s;
  logic [CW-1:0]     left_ext_s;
  logic [CNT_W-1:0]  cnt_sel_s;
  logic              hit_s;
  logic              unused_lfsr_s;

`ifdef CARD_SHOE_SEED_EN
  assign seed_take_s = seed_load && (state_r == S_IDLE);
  assign seed_val_s  = seed;
`else
  assign seed_take_s = 1'b0;
  assign seed_val_s  = '0;
`endif

  card_lfsr #(.W(LFSR_W), .SEED(LFSR_SEED)) u_lfsr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (seed_take_s),
    .load_value (seed_val_s),
    .state      (lfsr_s)
  );

  assign cand_s        = CW'(lfsr_s[IDX_W-1:0]);
  assign left_ext_s    = CW'(cards_left);
  assign cnt_sel_s     = cnt_r[rank_r - 4'd1];
  assign unused_lfsr_s = ^lfsr_s;
  assign low_shoe      = (cards_left < CUT_V);

  // Walk hit test; rank 10 closes the interval so the walk can never run off the end.
  always_comb begin
    if ((cand_r < (acc_r + CW'(cnt_sel_s))) || (rank_r == RANK_TEN)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Shoe FSM, rank counters and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      pend_r     <= 1'b0;
      cand_r     <= '0;
      acc_r      <= '0;
      rank_r     <= RANK_ACE;
      cards_left <= FULL_LEFT;
      ready      <= 1'b1;
      card_valid <= 1'b0;
      card_value <= 4'd0;
      reshuffled <= 1'b0;
      for (int i = 0; i < NUM_RANKS; i++) begin
        cnt_r[i] <= (i == NUM_RANKS - 1) ? FULL_TEN : FULL_LOW;
      end
    end else begin
      card_valid <= 1'b0;
      reshuffled <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (seed_take_s) begin
            state_r <= S_IDLE;
          end else if (shuffle_req) begin
            state_r <= S_FILL;
            pend_r  <= 1'b0;
            ready   <= 1'b0;
          end else if (draw_req) begin
            state_r <= (cards_left == '0) ? S_FILL : S_SAMPLE;
            pend_r  <= (cards_left == '0);
            ready   <= 1'b0;
          end
        end
        S_FILL: begin
          for (int i = 0; i < NUM_RANKS; i++) begin
            cnt_r[i] <= (i == NUM_RANKS - 1) ? FULL_TEN : FULL_LOW;
          end
          cards_left <= FULL_LEFT;
          reshuffled <= 1'b1;
          pend_r     <= 1'b0;
          state_r    <= pend_r ? S_SAMPLE : S_IDLE;
          ready      <= !pend_r;
        end
        S_SAMPLE: begin
          if (cand_s < left_ext_s) begin
            cand_r  <= cand_s;
            acc_r   <= '0;
            rank_r  <= RANK_ACE;
            state_r <= S_WALK;
          end
        end
        S_WALK: begin
          if (hit_s) begin
            state_r <= S_OUT;
          end else begin
            acc_r  <= acc_r + CW'(cnt_sel_s);
            rank_r <= rank_r + 4'd1;
          end
        end
        S_OUT: begin
          cnt_r[rank_r - 4'd1] <= cnt_sel_s - CNT_W'(1);
          cards_left           <= cards_left - CL_W'(1);
          card_value           <= rank_r;
          card_valid           <= 1'b1;
          state_r              <= S_IDLE;
          ready                <= 1'b1;
        end
        default: begin
          state_r <= S_IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe (NUM_DECKS=1): table of draw/shuffle operations plus
// hand-written reset-mid-walk, empty-shoe and (with CARD_SHOE_SEED_EN) seed-replay sequences.
module tb_card_shoe;
  import card_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       draw_req = 1'b0;
  logic       shuffle_req = 1'b0;
  logic       ready;
  logic       card_valid;
  logic [3:0] card_value;
  logic [5:0] cards_left;
  logic       low_shoe;
  logic       reshuffled;
`ifdef CARD_SHOE_SEED_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'h0000;
`endif

  card_shoe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .draw_req    (draw_req),
    .shuffle_req (shuffle_req),
`ifdef CARD_SHOE_SEED_EN
    .seed_load   (seed_load),
    .seed        (seed),
`endif
    .ready       (ready),
    .card_valid  (card_valid),
    .card_value  (card_value),
    .cards_left  (cards_left),
    .low_shoe    (low_shoe),
    .reshuffled  (reshuffled)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;          // 0 draw, 1 shuffle, 2 draw+shuffle together
    int exp_valid;
    int exp_resh;
    int exp_left;
  } vec_t;

  vec_t vecs[$];
  int   chk_cnt = 0;
  int   pass_cnt = 0;
  int   model [1:10];
  int   last_value = 0;

  task automatic check(input string name, input int got, input int exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic model_full();
    for (int r = 1; r <= 9; r++) model[r] = 4;
    model[10] = 16;
  endtask

  task automatic wait_ready();
    int guard;
    guard = 0;
    while (!ready && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (!ready) check("ready_wait", 0, 1);
  endtask

  task automatic run_op(input int op, output int n_valid, output int n_resh,
                        output int value, output int vlat);
    int lat;
    n_valid = 0; n_resh = 0; value = 0; vlat = 0;
    wait_ready();
    draw_req    = (op != 1);
    shuffle_req = (op != 0);
    @(negedge clk);
    draw_req    = 1'b0;
    shuffle_req = 1'b0;
    for (lat = 1; lat < 5000; lat++) begin
      if (card_valid) begin n_valid++; value = card_value; vlat = lat; end
      if (reshuffled) n_resh++;
      if (ready) break;
      @(negedge clk);
    end
    if (!ready) check("op_timeout", 0, 1);
  endtask

  task automatic apply(input string tag, input vec_t v);
    int nv, nr, val, vl;
    run_op(v.op, nv, nr, val, vl);
    check({tag, "_valid"}, nv, v.exp_valid);
    check({tag, "_resh"}, nr, v.exp_resh);
    check({tag, "_left"}, int'(cards_left), v.exp_left);
    check({tag, "_low"}, int'(low_shoe), (v.exp_left < 26) ? 1 : 0);
    if (nr > 0) model_full();
    if (nv > 0) begin
      check({tag, "_range"}, (val >= 1 && val <= 10) ? 1 : 0, 1);
      if (val >= 1 && val <= 10) begin
        check({tag, "_avail"}, (model[val] > 0) ? 1 : 0, 1);
        model[val]--;
        check({tag, "_latency"}, (vl >= 2 + val) ? 1 : 0, 1);
      end
      last_value = val;
    end else begin
      check({tag, "_held"}, int'(card_value), last_value);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_full();
    last_value = 0;
  endtask

`ifdef CARD_SHOE_SEED_EN
  task automatic load_seed(input logic [15:0] s);
    wait_ready();
    seed = s;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, nr, val, vl, guard, saw_valid;
    int seq_a [5];
    vec_t v;

    model_full();
    for (int i = 0; i < 10; i++) vecs.push_back('{0, 1, 0, 51 - i});
    vecs.push_back('{2, 0, 1, 52});
    for (int i = 0; i < 52; i++) vecs.push_back('{0, 1, 0, 51 - i});

    repeat (3) @(negedge clk);
    check("rst_ready", int'(ready), 1);
    check("rst_left", int'(cards_left), 52);
    check("rst_low", int'(low_shoe), 0);
    check("rst_valid", int'(card_valid), 0);
    check("rst_value", int'(card_value), 0);
    check("rst_resh", int'(reshuffled), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) apply($sformatf("vec%0d", i), vecs[i]);

    for (int r = 1; r <= 10; r++) check($sformatf("hist_left_r%0d", r), model[r], 0);

    // 53rd draw on an empty shoe: refill, then the card.
    v = '{0, 1, 1, 51};
    apply("empty_draw", v);

    // Reset while walking the rank table.
    wait_ready();
    draw_req = 1'b1;
    @(negedge clk);
    draw_req = 1'b0;
    guard = 0;
    while (dut.state_r != S_WALK && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    check("reach_walk", (dut.state_r == S_WALK) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(card_valid), 0);
    check("midrst_left", int'(cards_left), 52);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_full();
    last_value = 0;
    @(posedge clk);
    #1;
    check("post_rst_ready", int'(ready), 1);
    check("post_rst_left", int'(cards_left), 52);
    saw_valid = 0;
    repeat (15) begin
      @(negedge clk);
      if (card_valid) saw_valid++;
    end
    check("post_rst_no_valid", saw_valid, 0);

    v = '{0, 1, 0, 51};
    apply("after_rst_draw", v);

`ifdef CARD_SHOE_SEED_EN
    pulse_reset();
    load_seed(16'h1234);
    for (int i = 0; i < 5; i++) begin
      run_op(0, nv, nr, val, vl);
      seq_a[i] = val;
    end
    pulse_reset();
    load_seed(16'h1234);
    for (int i = 0; i < 5; i++) begin
      run_op(0, nv, nr, val, vl);
      check($sformatf("seed_replay%0d", i), val, seq_a[i]);
    end
`else
    seq_a[0] = 0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
